sram_bus_arbiter: RTL and testbench

//  Shares one SRAM-like slave port between the CPU instruction-fetch port and

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/arb_tag_fifo.sv | 59 +++++
 rtl/sram_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM-like bus arbiter.
//   tag_e                - identifies the master that owns a request or response
//   DEF_MAX_OUTSTANDING  - default depth of the outstanding-tag FIFO
//   DEF_STARVE_LIMIT     - default number of data grants before a waiting inst is forced
package sram_arb_pkg;

  typedef enum logic {
    TAG_INST = 1'b0,
    TAG_DATA = 1'b1
  } tag_e;

  localparam int DEF_MAX_OUTSTANDING = 2;
  localparam int DEF_STARVE_LIMIT    = 2;

endpackage

// File: rtl/arb_tag_fifo.sv
// 1-bit-wide tag FIFO that remembers which master issued each accepted request,
// so that in-order responses can be routed back to the right master.
//   clk, resetn      - clock, async active-low reset
//   push, push_tag   - store a tag (ignored when full)
//   pop              - discard the head tag (ignored when empty)
//   head_tag         - oldest stored tag
//   full, empty      - occupancy flags
module arb_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head_tag,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // DEPTH is a power of two, so masking implements the wrap.
  localparam logic [PW-1:0] PMASK = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_tag = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr + 1'b1) & PMASK;
      if (do_pop)  rd_ptr <= (rd_ptr + 1'b1) & PMASK;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like slave port between the instruction-fetch and data masters.
// Request phase: data has priority over inst unless inst has been passed over
// STARVE_LIMIT times; the grant is locked to its owner until addr_ok. Responses
// return in order and are steered by an outstanding-tag FIFO.
//   clk, resetn                 - clock, async active-low reset
//   inst_* / data_*             - master request fields, addr_ok/data_ok/rdata back
//   sram_*                      - muxed slave request, slave handshake and rdata
//   err_unexp_ok                - sticky: slave data_ok with nothing outstanding
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,
  output logic        err_unexp_ok
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // active stays low through reset and the first cycle after it, so every
  // output is derived from state and is quiet regardless of the inputs.
  logic          active;
  logic          lock;
  tag_e          owner;
  logic          err;
  logic [SW-1:0] starve_cnt;

  logic grant_vld;
  tag_e grant;
  logic grant_req;
  logic accept;
  logic rsp_vld;
  logic fifo_full;
  logic fifo_empty;
  logic head_tag;

  always_comb begin
    grant_vld = 1'b1;
    grant     = TAG_DATA;
    if (lock)                                            grant = owner;
    else if (inst_req && starve_cnt == STARVE_MAX)       grant = TAG_INST;
    else if (data_req)                                   grant = TAG_DATA;
    else if (inst_req)                                   grant = TAG_INST;
    else                                                 grant_vld = 1'b0;
  end

  assign grant_req = (grant == TAG_DATA) ? data_req : inst_req;
  // Full blocks the request even if a response pops this cycle, keeping
  // sram_data_ok off the combinational path to sram_req.
  assign sram_req  = active & grant_vld & grant_req & ~fifo_full;
  assign accept    = sram_req & sram_addr_ok;

  always_comb begin
    sram_wr    = 1'b0;
    sram_size  = '0;
    sram_wstrb = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (active && grant_vld) begin
      if (grant == TAG_DATA) begin
        sram_wr    = data_wr;
        sram_size  = data_size;
        sram_wstrb = data_wstrb;
        sram_addr  = data_addr;
        sram_wdata = data_wdata;
      end else begin
        sram_wr    = inst_wr;
        sram_size  = inst_size;
        sram_wstrb = inst_wstrb;
        sram_addr  = inst_addr;
        sram_wdata = inst_wdata;
      end
    end
  end

  assign inst_addr_ok = accept & (grant == TAG_INST);
  assign data_addr_ok = accept & (grant == TAG_DATA);

  assign rsp_vld      = active & sram_data_ok & ~fifo_empty;
  assign inst_data_ok = rsp_vld & (head_tag == TAG_INST);
  assign data_data_ok = rsp_vld & (head_tag == TAG_DATA);
  assign inst_rdata   = active ? sram_rdata : '0;
  assign data_rdata   = active ? sram_rdata : '0;
  assign err_unexp_ok = err;

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_tag (grant),
    .pop      (rsp_vld),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active     <= 1'b0;
      lock       <= 1'b0;
      owner      <= TAG_INST;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      active <= 1'b1;
      // A shown-but-unaccepted request pins the grant to its master.
      if (sram_req) begin
        lock  <= ~sram_addr_ok;
        owner <= grant;
      end
      if (!inst_req || (accept && grant == TAG_INST))
        starve_cnt <= '0;
      else if (accept && grant == TAG_DATA && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
      if (active && sram_data_ok && fifo_empty)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;
  import sram_arb_pkg::*;

  localparam int MAXO = 2;
  localparam int SLIM = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_addr, sram_wdata;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;
  logic        err_unexp_ok;

  sram_bus_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .STARVE_LIMIT    (SLIM)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_req     (sram_req),
    .sram_wr      (sram_wr),
    .sram_size    (sram_size),
    .sram_wstrb   (sram_wstrb),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_addr_ok (sram_addr_ok),
    .sram_data_ok (sram_data_ok),
    .sram_rdata   (sram_rdata),
    .err_unexp_ok (err_unexp_ok)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference model: queue of owners of accepted-but-unanswered requests,
  // the master currently holding the bus (if any) and how many times a
  // waiting inst has been passed over.
  bit q[$];
  bit m_held, m_holder, m_err, m_active;
  int m_passed_over;
  bit e_gv, e_gs, e_req, e_acc, e_dv, e_head;
  bit i_acc, d_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drv_inst(input logic req, input logic [31:0] addr);
    inst_req = req; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_addr = addr; inst_wdata = 32'h0;
  endtask

  task automatic drv_data(input logic req, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    data_req = req; data_wr = wr; data_size = size; data_wstrb = wr ? 4'hf : 4'h0;
    data_addr = addr; data_wdata = wdata;
  endtask

  task automatic slave(input logic aok, input logic dok, input logic [31:0] rd);
    sram_addr_ok = aok; sram_data_ok = dok; sram_rdata = rd;
  endtask

  // Compute what the outputs must be this cycle and compare.
  task automatic settle();
    logic [31:0] e_addr, e_wdata;
    logic [6:0]  e_ctl;
    #1;
    e_gv = 1'b1;
    e_gs = 1'b0;
    if (m_held)                                   e_gs = m_holder;
    else if (inst_req && m_passed_over == SLIM)   e_gs = 1'b0;
    else if (data_req)                            e_gs = 1'b1;
    else if (inst_req)                            e_gs = 1'b0;
    else                                          e_gv = 1'b0;
    e_req  = m_active && e_gv && (e_gs ? data_req : inst_req) && (q.size() < MAXO);
    e_acc  = e_req && sram_addr_ok;
    e_addr = 32'h0; e_wdata = 32'h0; e_ctl = 7'h0;
    if (m_active && e_gv) begin
      e_addr  = e_gs ? data_addr : inst_addr;
      e_wdata = e_gs ? data_wdata : inst_wdata;
      e_ctl   = e_gs ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb};
    end
    e_dv   = m_active && sram_data_ok && (q.size() > 0);
    e_head = (q.size() > 0) ? q[0] : 1'b0;
    check("sram_req", {31'h0, sram_req}, {31'h0, e_req});
    check("sram_addr", sram_addr, e_addr);
    check("sram_wdata", sram_wdata, e_wdata);
    check("sram_ctl", {25'h0, sram_wr, sram_size, sram_wstrb}, {25'h0, e_ctl});
    check("inst_addr_ok", {31'h0, inst_addr_ok}, {31'h0, e_acc && !e_gs});
    check("data_addr_ok", {31'h0, data_addr_ok}, {31'h0, e_acc && e_gs});
    check("inst_data_ok", {31'h0, inst_data_ok}, {31'h0, e_dv && !e_head});
    check("data_data_ok", {31'h0, data_data_ok}, {31'h0, e_dv && e_head});
    if (e_dv && !e_head) check("inst_rdata", inst_rdata, sram_rdata);
    if (e_dv && e_head)  check("data_rdata", data_rdata, sram_rdata);
    check("err_unexp_ok", {31'h0, err_unexp_ok}, {31'h0, m_err});
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_active) begin
      if (e_dv) void'(q.pop_front());
      else if (sram_data_ok) m_err = 1'b1;
      if (e_req) begin
        if (sram_addr_ok) begin q.push_back(e_gs); m_held = 1'b0; end
        else begin m_held = 1'b1; m_holder = e_gs; end
      end
      if (!inst_req || (e_acc && !e_gs)) m_passed_over = 0;
      else if (e_acc && e_gs && m_passed_over < SLIM) m_passed_over++;
    end
    m_active = 1'b1;
    i_acc = e_acc && !e_gs;
    d_acc = e_acc && e_gs;
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic model_reset();
    q.delete();
    m_held = 1'b0; m_holder = 1'b0; m_err = 1'b0; m_active = 1'b0; m_passed_over = 0;
    i_acc = 1'b0; d_acc = 1'b0;
  endtask

  task automatic drain();
    drv_inst(1'b0, 32'h0);
    drv_data(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
    while (q.size() > 0) begin
      slave(1'b0, 1'b1, $urandom());
      cyc();
    end
    slave(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    model_reset();
    drv_inst(1'b0, 32'h0);
    drv_data(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
    slave(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    check("rst_err", {31'h0, err_unexp_ok}, 32'h0);
    check("rst_req", {31'h0, sram_req}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    cyc();

    // 1: single inst read
    drv_inst(1'b1, 32'h1c000000); slave(1'b1, 1'b0, 32'h0);
    settle(); check("t1_iaok", {31'h0, inst_addr_ok}, 32'h1); tick();
    drv_inst(1'b0, 32'h0); slave(1'b0, 1'b0, 32'h0);
    cyc();
    slave(1'b0, 1'b1, 32'h02800c0c);
    settle();
    check("t1_idok", {31'h0, inst_data_ok}, 32'h1);
    check("t1_ddok", {31'h0, data_data_ok}, 32'h0);
    check("t1_rdata", inst_rdata, 32'h02800c0c);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    cyc();

    // 2: simultaneous requests, data first
    drv_inst(1'b1, 32'h1c000040);
    drv_data(1'b1, 1'b0, 2'd2, 32'h1c008000, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    settle();
    check("t2_addr", sram_addr, 32'h1c008000);
    check("t2_daok", {31'h0, data_addr_ok}, 32'h1);
    tick();
    drv_data(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
    settle(); check("t2_iaok", {31'h0, inst_addr_ok}, 32'h1); tick();
    drain();

    // 3: grant stays with inst while addr_ok is held off
    drv_inst(1'b1, 32'h1c000100); slave(1'b0, 1'b0, 32'h0);
    cyc();
    drv_data(1'b1, 1'b1, 2'd2, 32'h1c008040, 32'hdeadbeef);
    settle(); check("t3_lock1", sram_addr, 32'h1c000100); tick();
    settle(); check("t3_lock2", sram_addr, 32'h1c000100); tick();
    slave(1'b1, 1'b0, 32'h0);
    settle(); check("t3_iaok", {31'h0, inst_addr_ok}, 32'h1); tick();
    drv_inst(1'b0, 32'h0);
    settle(); check("t3_daok", {31'h0, data_addr_ok}, 32'h1); tick();
    drain();

    // 4: outstanding limit
    drv_inst(1'b1, 32'h1c000200); slave(1'b1, 1'b0, 32'h0);
    cyc();
    drv_inst(1'b1, 32'h1c000204);
    cyc();
    drv_inst(1'b1, 32'h1c000208); slave(1'b1, 1'b1, 32'h11111111);
    settle(); check("t4_full", {31'h0, sram_req}, 32'h0); tick();
    slave(1'b1, 1'b0, 32'h0);
    settle(); check("t4_resume", {31'h0, sram_req}, 32'h1); tick();
    drain();

    // 5a: in-order responses routed to each master
    drv_inst(1'b1, 32'h1c000300); slave(1'b1, 1'b0, 32'h0);
    cyc();
    drv_inst(1'b0, 32'h0); drv_data(1'b1, 1'b0, 2'd1, 32'h1c008100, 32'h0);
    cyc();
    drv_data(1'b0, 1'b0, 2'd2, 32'h0, 32'h0); slave(1'b0, 1'b1, 32'haaaa5555);
    settle(); check("t5_first", {30'h0, inst_data_ok, data_data_ok}, 32'h2); tick();
    slave(1'b0, 1'b1, 32'h5555aaaa);
    settle(); check("t5_second", {30'h0, inst_data_ok, data_data_ok}, 32'h1); tick();
    slave(1'b0, 1'b0, 32'h0);
    cyc();

    // 5b: anti-starvation after two data grants
    drv_inst(1'b1, 32'h1c000400);
    drv_data(1'b1, 1'b0, 2'd2, 32'h1c008200, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    cyc();
    drv_data(1'b1, 1'b0, 2'd2, 32'h1c008204, 32'h0);
    cyc();
    drv_data(1'b1, 1'b0, 2'd2, 32'h1c008208, 32'h0);
    slave(1'b1, 1'b1, 32'h0);
    cyc();
    slave(1'b1, 1'b0, 32'h0);
    settle();
    check("t5_starve_ok", {31'h0, inst_addr_ok}, 32'h1);
    check("t5_starve_addr", sram_addr, 32'h1c000400);
    tick();
    drain();

    // 6: unexpected data_ok, then reset mid-transaction
    slave(1'b0, 1'b1, 32'h0);
    cyc();
    slave(1'b0, 1'b0, 32'h0);
    settle(); check("t6_err", {31'h0, err_unexp_ok}, 32'h1); tick();
    drv_inst(1'b1, 32'h1c000500); slave(1'b1, 1'b0, 32'h0);
    cyc();
    drv_inst(1'b1, 32'h1c000504);
    drv_data(1'b1, 1'b1, 2'd2, 32'h1c008300, 32'h12345678);
    slave(1'b0, 1'b1, 32'hcafef00d);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check("t6_rst_ctl", {19'h0, sram_req, sram_wr, sram_size, sram_wstrb, inst_addr_ok,
          data_addr_ok, inst_data_ok, data_data_ok, err_unexp_ok}, 32'h0);
    check("t6_rst_bus", sram_addr | sram_wdata | inst_rdata | data_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    settle(); check("t6_post_req", {31'h0, sram_req}, 32'h0); tick();
    drv_inst(1'b0, 32'h0); drv_data(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
    slave(1'b0, 1'b1, 32'h0);
    settle(); check("t6_empty", {30'h0, inst_data_ok, data_data_ok}, 32'h0); tick();
    slave(1'b0, 1'b0, 32'h0);
    cyc();

    // Randomized traffic; masters hold their request until accepted.
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    drv_inst(1'b0, 32'h0); drv_data(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
    cyc();
    for (int c = 0; c < 400; c++) begin
      if (!inst_req || i_acc)
        drv_inst($urandom_range(0, 1) == 1, $urandom() & 32'hffff_fffc);
      if (!data_req || d_acc)
        drv_data($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 2)), $urandom(), $urandom());
      slave($urandom_range(0, 1) == 1, (q.size() > 0) && ($urandom_range(0, 2) != 0), $urandom());
      cyc();
    end
    drain();
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
